// File: rtl/wb_write_arbiter.sv
// Purpose: merges ALU and load results into the register file's single write port,
//          buffering them in order and forwarding pending data to the read ports.
// Latency: 1 edge via bypass when the queue is empty, else 1 + entries ahead; stall when count > DEPTH-2.
//
// Optional feature macro: WB_FORWARD_EN (read-port forwarding search; tied off when undefined).
//
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   memValid/memAddr/memData   - load result (older in program order when both fire)
//   aluValid/aluAddr/aluData   - ALU result
//   stall                      - producers must hold off their valids this cycle
//   writeEnable/writeAddr/d    - registered register file write port
//   ra, rb                     - snooped register file read addresses
//   fwdAHit/fwdA, fwdBHit/fwdB - youngest pending write matching ra / rb
//   overflow                   - sticky: a valid arrived while stall was high
module wb_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    output logic              stall,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              fwdAHit,
    output logic              fwdBHit,
    output logic [DATA_W-1:0] fwdA,
    output logic [DATA_W-1:0] fwdB,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_d [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [DATA_W-1:0] q_data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              overflow_q, overflow_d;

    logic              mem_acc, alu_acc;
    logic              push_mem, push_alu, pop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  n_enq;

    // Stall leaves room for two enqueues even if nothing drains, so full is never reached.
    assign stall = (count_q > CNT_W'(DEPTH - 2));

    always_comb begin
        mem_acc    = memValid & ~stall;
        alu_acc    = aluValid & ~stall;
        overflow_d = overflow_q | ((memValid | aluValid) & stall);

        q_addr_d = q_addr_q;
        q_data_d = q_data_q;
        head_d   = head_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        push_mem = 1'b0;
        push_alu = 1'b0;
        pop      = 1'b0;

        if (count_q != '0) begin
            // Older entries drain first; new results join behind them.
            pop      = 1'b1;
            we_d     = 1'b1;
            waddr_d  = q_addr_q[head_q];
            wdata_d  = q_data_q[head_q];
            head_d   = head_q + PTR_W'(1);
            push_mem = mem_acc;
            push_alu = alu_acc;
        end else if (mem_acc) begin
            // Empty queue: the load bypasses, an ALU result in the same cycle waits one slot.
            we_d     = 1'b1;
            waddr_d  = memAddr;
            wdata_d  = memData;
            push_alu = alu_acc;
        end else if (alu_acc) begin
            we_d    = 1'b1;
            waddr_d = aluAddr;
            wdata_d = aluData;
        end

        // Mem is written before alu so the load keeps its program-order position.
        wr_ptr = tail_q;
        n_enq  = '0;
        if (push_mem) begin
            q_addr_d[wr_ptr] = memAddr;
            q_data_d[wr_ptr] = memData;
            wr_ptr           = wr_ptr + PTR_W'(1);
            n_enq            = n_enq + CNT_W'(1);
        end
        if (push_alu) begin
            q_addr_d[wr_ptr] = aluAddr;
            q_data_d[wr_ptr] = aluData;
            wr_ptr           = wr_ptr + PTR_W'(1);
            n_enq            = n_enq + CNT_W'(1);
        end
        tail_d  = wr_ptr;
        count_d = count_q + n_enq - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_q[i] <= '0;
                q_data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            q_addr_q   <= q_addr_d;
            q_data_q   <= q_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            overflow_q <= overflow_d;
        end
    end

    assign writeEnable = we_q;
    assign writeAddr   = waddr_q;
    assign d           = wdata_q;
    assign overflow    = overflow_q;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fa_idx, fb_idx;

    // Scan oldest to youngest (output register, then head..tail-1); later
    // matches overwrite earlier ones so the youngest pending data wins.
    always_comb begin
        fwdAHit = 1'b0;
        fwdA    = '0;
        fwdBHit = 1'b0;
        fwdB    = '0;
        fa_idx  = head_q;
        fb_idx  = head_q;
        if (we_q && (waddr_q == ra)) begin
            fwdAHit = 1'b1;
            fwdA    = wdata_q;
        end
        if (we_q && (waddr_q == rb)) begin
            fwdBHit = 1'b1;
            fwdB    = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fa_idx = head_q + PTR_W'(i);
            fb_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (q_addr_q[fa_idx] == ra)) begin
                fwdAHit = 1'b1;
                fwdA    = q_data_q[fa_idx];
            end
            if ((CNT_W'(i) < count_q) && (q_addr_q[fb_idx] == rb)) begin
                fwdBHit = 1'b1;
                fwdB    = q_data_q[fb_idx];
            end
        end
    end
`else
    // Consumers handle hazards themselves; read addresses are not observed.
    logic unused_rd;
    assign unused_rd = ^{ra, rb};
    assign fwdAHit   = 1'b0;
    assign fwdBHit   = 1'b0;
    assign fwdA      = '0;
    assign fwdB      = '0;
`endif

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back stage arbiter in front of the register file's single write port (`writeEnable`/`writeAddr`/`d`). It accepts results from the ALU path and the load path, which may both complete in the same cycle. Results are buffered in order in a small queue and drained one write per cycle. It also provides read-port forwarding so that a read does not return stale data while a write is still pending.

## Interface
- `DATA_W`, 16, data width (matches register file `d`)
- `ADDR_W`, 3, register address width
- `DEPTH`, 4, pending-write queue entries (power of two, ≥2)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `memValid` in 1: load result valid this cycle
- `memAddr` in ADDR_W: load destination register
- `memData` in DATA_W: load data
- `aluValid` in 1: ALU result valid this cycle
- `aluAddr` in ADDR_W: ALU destination register
- `aluData` in DATA_W: ALU data
- `stall` out 1: producers must not assert a valid in this cycle
- `writeEnable` out 1: register file write strobe (registered)
- `writeAddr` out ADDR_W: register file write address (registered)
- `d` out DATA_W: register file write data (registered)
- `ra`, `rb` in ADDR_W: register file read addresses, snooped
- `fwdAHit`, `fwdBHit` out 1: a pending write matches `ra` / `rb`
- `fwdA`, `fwdB` out DATA_W: youngest pending data for `ra` / `rb`
- `overflow` out 1: sticky error flag

## Operation
- The queue is a circular buffer with `head`, `tail` and `count` (0..DEPTH).
- Enqueue order when both inputs are valid: mem first, then alu. The load is older in program order.
- Dequeue: when `count>0` at a rising edge, the head entry is loaded into the output registers, `writeEnable=1` and `head` advances. Otherwise `writeEnable=0`.
- Bypass: when `count==0` and exactly one valid input is present, the input goes directly to the output registers and is not enqueued.
- When `count==0` and both inputs are valid: mem goes to the output registers and alu is enqueued.
- Enqueue and dequeue in the same cycle are allowed. `count` updates by (+enq −deq).
- `stall` is combinational from the registered `count`: `stall = (count > DEPTH-2)`. This guarantees room for 2 enqueues plus 1 dequeue.
- A valid asserted while `stall=1`:
  - The entry is dropped and not enqueued.
  - `overflow` is set and stays 1 until `reset`.
- Forwarding (per read port, combinational):
  - Matches are searched across queue entries from tail−1 down to head, then the output register when `writeEnable=1`.
  - The first match wins (youngest data).
  - With no match, `hit=0` and data=0.
- Address 0 has no special treatment; every address is written as received.

## Timing
- Reset values:
  - `writeEnable=0`, `writeAddr=0`, `d=0`, `stall=0`, `overflow=0`, `fwd*Hit=0`, `fwd*=0`.
  - `head=tail=count=0`.
- Reset asserted mid-operation discards all queued entries at that edge. No write issues in the following cycle.
- Latency from input sampled at edge E to a visible write:
  - 1 edge when the bypass applies (outputs valid after E, register file commits at E+1).
  - Otherwise 1 + (entries ahead of it) edges.
- Throughput: one write per cycle. Sustained dual-issue fills the queue at 1 net entry per cycle until `stall` asserts.
- Pointer wrap: `head`/`tail` wrap modulo DEPTH. Full is `count==DEPTH`, which is unreachable when producers respect `stall`.

## Configuration
- `WB_FORWARD_EN` defined: the forwarding search is compiled in as described.
- `WB_FORWARD_EN` undefined: `fwdAHit`, `fwdBHit`, `fwdA` and `fwdB` are tied to 0, and `ra`/`rb` are unused. The consumer must then stall on hazards itself; `stall` is unchanged.

## Test plan
- Reset, then aluValid=1 with addr=1, data=0x0005 for one cycle → next cycle `writeEnable=1`, `writeAddr=1`, `d=0x0005`; cycle after that `writeEnable=0`.
- memValid with addr=2, data=0x00AA and aluValid with addr=3, data=0x00BB in the same cycle → writes are addr 2 then addr 3 on consecutive cycles; count peaks at 1.
- Dual-issue every cycle until stall → `stall` rises when count=3 (DEPTH=4); a valid forced during stall sets `overflow=1`; the queue drains in FIFO order with no lost entries.
- Two queued writes to addr 4 (0x0011 then 0x0022), ra=4 → `fwdAHit=1`, `fwdA=0x0022`; after both drain, `fwdAHit=0`.
- Queue holding 3 entries, `reset` pulsed for one cycle → `writeEnable=0` on the next cycle, count=0, `stall=0`, `overflow=0`.
- Build without `WB_FORWARD_EN`, repeat the forwarding scenario → `fwdAHit=0`, `fwdA=0`; write sequence is identical.
